vga_timing_gen: RTL

Pixel-timing generator for the VGA path. It produces the pixel tick, the horizontal and vertical scan counters, sync pulses, video_on and line/frame markers. It sits directly upstream of the text/font generation stage and the RGB output buffer, which consume pixel_x/pixel_y/video_on/p_tick. It is fully parameterised for arbitrary timing and defaults to 640x480@60 Hz from a 50 MHz clock.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_tick_div.sv | 47 ++++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared timing constants, coordinate type and helpers for the
//               VGA timing generator. Defaults describe 640x480@60 Hz driven
//               from a 50 MHz clock with a divide-by-2 pixel tick.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Coordinate width; both scan totals must fit in this many bits.
  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 timing (pixels / lines).
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_TICK_DIV  = 2;

  // Sync pulses are active-low for the default mode.
  localparam bit DEF_SYNC_ACTIVE = 1'b0;

  function automatic int h_total(input int disp, input int front,
                                 input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(input int disp, input int front,
                                 input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : vga_tick_div
// Description : Pixel-tick divider. Emits a one-clock strobe every TICK_DIV
//               clocks; the strobe is decoded from the counter register so it
//               is glitch-free. With TICK_DIV == 1 the strobe is constant 1.
// Revision    : 1.0 - initial release
// Ports       : clk    - system clock
//               reset  - synchronous, active-low reset
//               p_tick - one-clk pixel-enable strobe
// ============================================================================
module vga_tick_div #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  generate
    if (TICK_DIV <= 1) begin : g_passthru
      // Every clock is a pixel clock; clk/reset are intentionally unused.
      logic unused_inputs;
      assign unused_inputs = clk ^ reset;
      assign p_tick        = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(TICK_DIV);
      localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

      logic [CW-1:0] tick_cnt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      assign p_tick = (tick_cnt == LAST);
    end
  endgenerate

endmodule : vga_tick_div
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parameterised VGA pixel-timing generator. Produces the pixel
//               tick, scan counters, sync pulses, video_on and line/frame
//               markers for the downstream text and RGB stages.
// Revision    : 1.0 - initial release
// Ports       : clk          - system clock
//               reset        - synchronous, active-low reset
//               hsync/vsync  - sync pulses, asserted level = SYNC_ACTIVE
//               video_on     - inside the visible window
//               p_tick       - one-clk pixel-enable strobe
//               pixel_x/y    - current column / row
//               end_of_line  - p_tick on the last column
//               end_of_frame - end_of_line on the last row
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic         clk,
  input  logic         reset,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         p_tick,
  output logic [9:0]   pixel_x,
  output logic [9:0]   pixel_y,
  output logic         end_of_line,
  output logic         end_of_frame
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // One bit wider so a display width equal to the full coordinate range
  // still compares correctly.
  localparam logic [COORD_W:0] H_DISP_W = (COORD_W+1)'(H_DISPLAY);
  localparam logic [COORD_W:0] V_DISP_W = (COORD_W+1)'(V_DISPLAY);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || TICK_DIV < 1) begin : g_param_check
      $error("vga_timing_gen: totals must be <= %0d and TICK_DIV >= 1", MAX_TOTAL);
    end
  endgenerate

  vga_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  coord_t x_next;
  coord_t y_next;
  logic   hsync_next;
  logic   vsync_next;
  logic   at_line_end;

  assign at_line_end = (pixel_x == H_LAST);

  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      if (at_line_end) begin
        x_next = '0;
        y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
      end else begin
        x_next = pixel_x + 1'b1;
      end
    end
  end

  // Syncs decode the counters' next values so they update on the same edge
  // as pixel_x/pixel_y and never skew against them.
  always_comb begin
    hsync_next = ((x_next >= HS_START) && (x_next <= HS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    vsync_next = ((y_next >= VS_START) && (y_next <= VS_END)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
      hsync   <= !SYNC_ACTIVE;
      vsync   <= !SYNC_ACTIVE;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= hsync_next;
      vsync   <= vsync_next;
    end
  end

  assign video_on     = ({1'b0, pixel_x} < H_DISP_W) && ({1'b0, pixel_y} < V_DISP_W);
  assign end_of_line  = p_tick && at_line_end;
  assign end_of_frame = end_of_line && (pixel_y == V_LAST);

endmodule : vga_timing_gen
`default_nettype wire
